// File: rtl/addsub_pkg.sv
// Shared types and helpers for the add/subtract sequencer.
package addsub_pkg;

  localparam int WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_B = 2'd1,
    CALC   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Subtraction is A + ~B + 1; the +1 enters as the adder carry-in.
  function automatic logic [WIDTH-1:0] cond_b(input logic [WIDTH-1:0] b, input logic sub);
    return b ^ {WIDTH{sub}};
  endfunction

endpackage

// File: rtl/addsub_sequencer_if.sv
// Operand and result handshake bundle between upstream, the sequencer and the display stage.
// Handshake: a transfer happens on a rising edge where valid && ready; the producer holds
// its data stable while valid is high and ready is low.
interface addsub_sequencer_if;
  import addsub_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din;
  logic             sub;
  logic             acc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport slave (
    input  in_valid, din, sub, acc, out_ready,
    output in_ready, out_valid, result, cout, ovf
  );

  modport master (
    output in_valid, din, sub, acc, out_ready,
    input  in_ready, out_valid, result, cout, ovf
  );
endinterface

// File: rtl/adder4.sv
// Four-bit ripple-carry adder with carry-out and signed overflow.
module adder4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c0_i,
  output logic [3:0] s_o,
  output logic       c4_o,
  output logic       v_o
);
  logic [4:0] c;

  assign c[0] = c0_i;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    fulladder u_fa (
      .a_i  (a_i[i]),
      .b_i  (b_i[i]),
      .ci_i (c[i]),
      .s_o  (s_o[i]),
      .co_o (c[i+1])
    );
  end

  assign c4_o = c[4];
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign v_o  = c[4] ^ c[3];
endmodule

// File: rtl/fulladder.sv
// One-bit full adder cell used by the ripple-carry adder.
module fulladder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

// File: rtl/addsub_sequencer.sv
// Sequences two operands (or accumulator + operand) through adder4 and hands the
// registered result downstream over a valid/ready handshake.
module addsub_sequencer #(
  parameter int WIDTH  = 4,
  parameter bit ACC_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  addsub_sequencer_if.slave     bus,
  output addsub_pkg::state_t    state_o
);
  import addsub_pkg::*;

  if (WIDTH != 4) begin : g_bad_width
    $error("addsub_sequencer: WIDTH must be 4");
  end

  state_t     state_q;
  logic [3:0] rega_q;
  logic [3:0] regb_q;
  logic [3:0] acc_q;
  logic       sub_q;
  logic [3:0] result_q;
  logic       cout_q;
  logic       ovf_q;
  logic       out_valid_q;

  logic [3:0] sum;
  logic       c4;
  logic       v;

  adder4 u_adder4 (
    .a_i  (rega_q),
    .b_i  (cond_b(regb_q, sub_q)),
    .c0_i (sub_q),
    .s_o  (sum),
    .c4_o (c4),
    .v_o  (v)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rega_q      <= '0;
      regb_q      <= '0;
      acc_q       <= '0;
      sub_q       <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (clr_i) begin
      state_q     <= IDLE;
      rega_q      <= '0;
      regb_q      <= '0;
      acc_q       <= '0;
      sub_q       <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            sub_q <= bus.sub;
            if (ACC_EN && bus.acc) begin
              rega_q  <= acc_q;
              regb_q  <= bus.din;
              state_q <= CALC;
            end else begin
              rega_q  <= bus.din;
              state_q <= WAIT_B;
            end
          end
        end
        WAIT_B: begin
          if (bus.in_valid) begin
            regb_q  <= bus.din;
            state_q <= CALC;
          end
        end
        CALC: begin
          result_q    <= sum;
          cout_q      <= c4;
          ovf_q       <= v;
          acc_q       <= sum;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE) || (state_q == WAIT_B);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_addsub_sequencer.sv
// Bench for addsub_sequencer: directed scenarios plus random operations, checked by a
// scoreboard fed from an arithmetic reference model.
module tb_addsub_sequencer;
  import addsub_pkg::*;

  logic   clk;
  logic   rst;
  logic   clr;
  state_t state;
  logic   rand_bp;

  int checks;
  int errors;

  logic [5:0] exp_q[$];
  logic [3:0] acc_m;

  addsub_sequencer_if bus ();

  addsub_sequencer #(.WIDTH(4), .ACC_EN(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr),
    .bus     (bus),
    .state_o (state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, returns {result, cout, ovf}.
  function automatic logic [5:0] ref_op(input int a, input int b, input bit s);
    int sa, sb, r, sr;
    bit c, v;
    logic [3:0] rr;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    if (!s) begin
      r  = a + b;
      c  = (r > 15);
      sr = sa + sb;
    end else begin
      r  = a - b;
      c  = (a >= b);
      sr = sa - sb;
    end
    v  = (sr > 7) || (sr < -8);
    rr = 4'(r & 15);
    return {rr, c, v};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic put(input logic [3:0] d, input logic s, input logic a);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.din      = d;
    bus.sub      = s;
    bus.acc      = a;
    while (!bus.in_ready && n < 60) begin
      if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 8'(bus.in_ready), 8'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.acc      = 1'b0;
  endtask

  task automatic op(input logic [3:0] a, input logic [3:0] b, input logic s, input logic s_at_b);
    logic [5:0] e;
    put(a, s, 1'b0);
    e = ref_op(int'(a), int'(b), s);
    exp_q.push_back(e);
    acc_m = e[5:2];
    put(b, s_at_b, 1'b0);
  endtask

  task automatic acc_op(input logic [3:0] b, input logic s);
    logic [5:0] e;
    e = ref_op(int'(acc_m), int'(b), s);
    exp_q.push_back(e);
    acc_m = e[5:2];
    put(b, s, 1'b1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(state == IDLE && !bus.out_valid) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_idle", 8'(state == IDLE), 8'd1);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 8'(bus.out_valid), 8'd0);
        end else begin
          e = exp_q.pop_front();
          check("result", 8'(bus.result), 8'(e[5:2]));
          check("cout", 8'(bus.cout), 8'(e[1]));
          check("ovf", 8'(bus.ovf), 8'(e[0]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] ra, rb;
    int n;
    checks = 0;
    errors = 0;
    rand_bp = 1'b0;
    acc_m = '0;
    rst = 1'b1;
    clr = 1'b0;
    bus.in_valid  = 1'b0;
    bus.din       = '0;
    bus.sub       = 1'b0;
    bus.acc       = 1'b0;
    bus.out_ready = 1'b1;

    #12;
    check("rst_out_valid", 8'(bus.out_valid), 8'd0);
    check("rst_in_ready", 8'(bus.in_ready), 8'd1);
    check("rst_result", 8'(bus.result), 8'd0);
    check("rst_state", 8'(state), 8'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: latency and handshake around CALC/DONE
    put(4'd5, 1'b0, 1'b0);
    check("t1_wait_b_ready", 8'(bus.in_ready), 8'd1);
    exp_q.push_back(ref_op(5, 3, 1'b0));
    acc_m = 4'd8;
    put(4'd3, 1'b0, 1'b0);
    check("t1_calc_in_ready", 8'(bus.in_ready), 8'd0);
    check("t1_calc_out_valid", 8'(bus.out_valid), 8'd0);
    @(posedge clk); #1;
    check("t1_done_out_valid", 8'(bus.out_valid), 8'd1);
    check("t1_done_in_ready", 8'(bus.in_ready), 8'd0);
    check("t1_result", 8'(bus.result), 8'h8);
    @(posedge clk); #1;
    check("t1_idle_out_valid", 8'(bus.out_valid), 8'd0);
    check("t1_idle_in_ready", 8'(bus.in_ready), 8'd1);

    // 2-4: subtraction, boundaries, accumulate (Sub flipped while supplying B)
    op(4'd3, 4'd5, 1'b1, 1'b0);
    op(4'd5, 4'd3, 1'b1, 1'b0);
    acc_op(4'hF, 1'b0);
    acc_op(4'd1, 1'b1);
    op(4'd8, 4'd1, 1'b1, 1'b0);
    op(4'hF, 4'd1, 1'b0, 1'b1);
    wait_idle();

    // 5: backpressure in DONE with ignored operand pulses
    bus.out_ready = 1'b0;
    op(4'd6, 4'd1, 1'b0, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("t5_out_valid", 8'(bus.out_valid), 8'd1);
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.din      = 4'd9;
      @(posedge clk); #1;
      check("t5_hold_valid", 8'(bus.out_valid), 8'd1);
      check("t5_hold_result", 8'(bus.result), 8'd7);
      check("t5_hold_flags", 8'({bus.cout, bus.ovf}), 8'd0);
      check("t5_in_ready", 8'(bus.in_ready), 8'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("t5_idle", 8'(state), 8'(IDLE));
    check("t5_result_kept", 8'(bus.result), 8'd7);

    // 6: asynchronous reset mid-WAIT_B, then Clr beats a concurrent input
    put(4'd4, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check("t6_rst_result", 8'(bus.result), 8'd0);
    check("t6_rst_out_valid", 8'(bus.out_valid), 8'd0);
    check("t6_rst_in_ready", 8'(bus.in_ready), 8'd1);
    check("t6_rst_state", 8'(state), 8'(IDLE));
    acc_m = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    op(4'd2, 4'd2, 1'b0, 1'b0);
    wait_idle();
    clr          = 1'b1;
    bus.in_valid = 1'b1;
    bus.din      = 4'd7;
    @(posedge clk); #1;
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    acc_m        = '0;
    check("t6_clr_state", 8'(state), 8'(IDLE));
    check("t6_clr_result", 8'(bus.result), 8'd0);
    acc_op(4'd3, 1'b0);
    op(4'd2, 4'd2, 1'b0, 1'b0);
    wait_idle();

    // random operations with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) acc_op(rb, 1'($urandom_range(0, 1)));
      else op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    rand_bp = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 8'(exp_q.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/addsub_sequencer.md
Name: addsub_sequencer

Overview:
Sequential front-end/back-end wrapper around the 4-bit ripple-carry adder `adder4`. It accepts two 4-bit operands one at a time over a valid/ready handshake, or one operand plus the running accumulator. It conditions B for add or subtract (B XOR Sub, C0 = Sub), drives `adder4`, and registers the sum, carry and overflow. Results are presented on a valid/ready output handshake to downstream logic (display/LED stage).

Parameters:
- WIDTH, 4, operand width. Only 4 is legal; any other value is an elaboration-time error.
- ACC_EN, 1, enables accumulate mode. When 0, the Acc input is ignored.

Ports:
- Clock  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Clr  input  1  synchronous clear of the accumulator and FSM.
- In_valid  input  1  Din/Sub/Acc are valid this cycle.
- In_ready  output  1  block can accept an operand this cycle.
- Din  input  4  operand value.
- Sub  input  1  operation select: 0 = add, 1 = subtract. Sampled with the first operand only.
- Acc  input  1  use the accumulator as A; Din becomes B. Sampled in IDLE only.
- Out_valid  output  1  Result/Cout/Ovf are valid.
- Out_ready  input  1  downstream accepts the result.
- Result  output  4  registered sum/difference.
- Cout  output  1  registered carry-out (C4). For subtract: 1 = no borrow (A >= B unsigned).
- Ovf  output  1  registered signed overflow, equal to C4 XOR c3.

Behaviour:
- **Reset (async, active-high):** state=IDLE. regA, regB, acc_r, sub_r, Result, Cout, Ovf, Out_valid = 0. In_ready=1 (combinational from state). Takes effect immediately, including mid-operation; any partial operation is discarded.
- **Transfer rule:** an input transfer occurs at a rising edge with In_valid && In_ready. An output transfer occurs with Out_valid && Out_ready.
- **In_ready** is 1 in IDLE and WAIT_B, and 0 in CALC and DONE. Din/Sub/Acc are ignored whenever In_ready=0.
- **FSM states:** IDLE, WAIT_B, CALC, DONE.
  - **IDLE**, transfer with Acc=0 (or ACC_EN=0): regA<=Din, sub_r<=Sub, go to WAIT_B.
  - **IDLE**, transfer with Acc=1 and ACC_EN=1: regA<=acc_r, regB<=Din, sub_r<=Sub, go to CALC.
  - **WAIT_B**, transfer: regB<=Din, go to CALC. Sub is ignored here.
  - **CALC** (exactly one cycle): adder4 inputs are A=regA, B=regB XOR {4{sub_r}}, C0=sub_r. At the edge: Result<=S, Cout<=C4, Ovf<=V, acc_r<=S, Out_valid<=1, go to DONE.
  - **DONE:** outputs hold stable while Out_ready=0 (no limit). On output transfer: Out_valid<=0, go to IDLE. Result/Cout/Ovf keep their last values after hand-off.
- **Latency:** Out_valid rises at the edge following the B-acceptance edge (one CALC cycle). Minimum operation is 4 cycles (A, B, CALC, DONE with Out_ready=1), or 3 in accumulate mode.
- **No overlap:** a new operand is never accepted while a result is pending.
- **Clr:**
  - Priority over all handshakes (Reset excepted).
  - At the edge: state=IDLE, acc_r=0, Out_valid=0, regA/regB/sub_r=0. Result/Cout/Ovf are cleared to 0.
  - A concurrent In_valid or Out_ready transfer is dropped.
- **Width rules:**
  - All arithmetic is mod 16; Cout and Ovf are the only indication of range overflow.
  - Ovf is meaningful for two's-complement operands, Cout for unsigned operands.
- **Accumulator:**
  - Holds the last Result.
  - Unaffected by output hand-off.
  - Wraps mod 16.

Decomposition:
- Package `addsub_pkg`:
  - WIDTH constant (4).
  - `state_t` enum {IDLE, WAIT_B, CALC, DONE}.
  - Function `cond_b(b, sub)` returning b XOR {WIDTH{sub}}.
- Sub-module: the existing `adder4` (and its `fulladder` cells), instantiated once, unchanged. All sequencing and B-conditioning live in `addsub_sequencer`.

Test Plan:
1. Reset, then A=5, B=3, Sub=0, Out_ready=1 → Out_valid one cycle after B accepted; Result=8, Cout=0, Ovf=1; In_ready low in CALC/DONE.
2. A=3, B=5, Sub=1 → Result=0xE, Cout=0, Ovf=0. Then A=5, B=3, Sub=1 → Result=2, Cout=1, Ovf=0. Sub toggled during WAIT_B has no effect.
3. A=8, B=1, Sub=1 → Result=7, Cout=1, Ovf=1. Then A=0xF, B=1, Sub=0 → Result=0, Cout=1, Ovf=0.
4. After Result=2, Acc=1, Din=0xF, Sub=0 → no WAIT_B; Result=1, Cout=1, Ovf=0. Then Acc=1, Din=1, Sub=1 → Result=0, Cout=1.
5. Backpressure: hold Out_ready=0 for 6 cycles in DONE while pulsing In_valid with Din=9 → Out_valid, Result, Cout and Ovf stable; no input transfer; Out_ready=1 → IDLE next edge.
6. Assert Reset asynchronously mid-WAIT_B (between edges) → outputs 0 and In_ready=1 immediately. Assert Clr with In_valid=1 in IDLE → acc_r=0, no transfer. Next op 2+2 → 4.
